// File: rtl/mem_responder.sv
// mem_responder: word-addressed 16-bit memory on the processor bus.
// Each request inserts WAIT wait states, performs one access, then ends
// with a one-cycle ack pulse. Read data is registered and held until the
// next completed read.
//
// Optional feature: define MEM_RANGE_CHECK_EN to allow any DEPTH from
// 1 to 65536. Addresses >= DEPTH then complete with err=1: a write is
// dropped and a read returns 0. Without the macro, DEPTH must be a power
// of two, addresses wrap modulo DEPTH, and err is tied low.
//
// Handshake: req/we/addr/wdata are sampled only on an edge where the
// block is IDLE (busy=0). Requests are ignored while busy=1. Completion
// is the single-cycle ack, and rdata/err are valid during that cycle.
module mem_responder #(
    parameter int DEPTH = 4096,
    parameter int WAIT  = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        we,
    input  logic [15:0] addr,
    input  logic [15:0] wdata,
    output logic        ack,
    output logic [15:0] rdata,
    output logic        busy,
    output logic        err,
    output logic [1:0]  fsm_state
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_WAIT   = 2'd1;
    localparam logic [1:0] S_ACCESS = 2'd2;
    localparam logic [1:0] S_ACK    = 2'd3;

    localparam logic [3:0] WAIT_LOAD = 4'(WAIT);

    logic [1:0]    state;
    logic [3:0]    cnt;
    logic          we_q;
    logic [15:0]   addr_q;
    logic [15:0]   wdata_q;
    logic [AW-1:0] idx;
    logic          in_range;

    logic [15:0] mem [0:DEPTH-1];

    assign idx       = addr_q[AW-1:0];
    assign busy      = (state != S_IDLE);
    assign fsm_state = state;

`ifdef MEM_RANGE_CHECK_EN
    logic err_q;

    assign in_range = ({1'b0, addr_q} < 17'(DEPTH));
    assign err      = err_q;

    // Out-of-range flag, raised only in the ack cycle of a bad access
    always_ff @(posedge clk) begin
        if (reset) begin
            err_q <= 1'b0;
        end else begin
            err_q <= (state == S_ACCESS) && !in_range;
        end
    end
`else
    // Upper address bits are intentionally dropped: addresses wrap.
    logic unused_addr;

    assign in_range    = 1'b1;
    assign err         = 1'b0;
    assign unused_addr = ^addr_q;
`endif

    // Transaction sequencer: latch request, count wait states, access, ack
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= S_IDLE;
            cnt     <= 4'd0;
            ack     <= 1'b0;
            rdata   <= 16'h0000;
            we_q    <= 1'b0;
            addr_q  <= 16'h0000;
            wdata_q <= 16'h0000;
        end else begin
            ack <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (req) begin
                        we_q    <= we;
                        addr_q  <= addr;
                        wdata_q <= wdata;
                        cnt     <= WAIT_LOAD;
                        state   <= (WAIT_LOAD != 4'd0) ? S_WAIT : S_ACCESS;
                    end
                end
                S_WAIT: begin
                    cnt <= cnt - 4'd1;
                    // Counter holds WAIT on entry, so this state lasts WAIT cycles
                    if (cnt <= 4'd1) begin
                        state <= S_ACCESS;
                    end
                end
                S_ACCESS: begin
                    if (!we_q) begin
                        rdata <= in_range ? mem[idx] : 16'h0000;
                    end
                    ack   <= 1'b1;
                    state <= S_ACK;
                end
                S_ACK: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // Memory write at the closing edge of ACCESS; reset aborts it
    always_ff @(posedge clk) begin
        if (!reset && (state == S_ACCESS) && we_q && in_range) begin
            mem[idx] <= wdata_q;
        end
    end

endmodule
